div_mult_engine: RTL and testbench

// - Multi-cycle MULT/MULTU/DIV/DIVU unit in EXE. Drives DIVMULTBusy into the pipeline Control unit.
// - Consumes Control's EXE_Wr, EXE_DisWr and Flush_Exception.
// - Produces HI/LO results and a single-cycle HILO write enable.
// - Implements the responder side of the busy/stall handshake that Control initiates on.

---
 rtl/cpu_defs_pkg.sv | 22 ++
 rtl/div_mult_engine_if.sv | 27 ++
 rtl/div_radix2_core.sv | 82 ++++++++
 rtl/div_mult_engine.sv | 164 ++++++++++++++++
 tb/tb_div_mult_engine.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared MDU types: operation and FSM state encodings, divider iteration count.
// Pure definitions; no timing or flow control.
package cpu_defs_pkg;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4
  } mdu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_t;

  localparam int MDU_DIV_ITER = 32;

endpackage

// File: rtl/div_mult_engine_if.sv
// EXE-stage <-> MDU bundle; Control (master) drives op/operands/advance, MDU (slave) answers busy/results.
// Busy is the only backpressure: Control freezes EXE while DIVMULTBusy is high.
interface div_mult_engine_if #(parameter int DATA_W = 32);
  import cpu_defs_pkg::*;

  mdu_op_t             EXE_MdOp;
  logic [DATA_W-1:0]   EXE_SrcA;
  logic [DATA_W-1:0]   EXE_SrcB;
  logic                EXE_Wr;
  logic                EXE_DisWr;
  logic                Flush_Exception;
  logic                DIVMULTBusy;
  logic [DATA_W-1:0]   EXE_Hi;
  logic [DATA_W-1:0]   EXE_Lo;
  logic                HiLo_We;

  modport master (
    output EXE_MdOp, EXE_SrcA, EXE_SrcB, EXE_Wr, EXE_DisWr, Flush_Exception,
    input  DIVMULTBusy, EXE_Hi, EXE_Lo, HiLo_We
  );

  modport slave (
    input  EXE_MdOp, EXE_SrcA, EXE_SrcB, EXE_Wr, EXE_DisWr, Flush_Exception,
    output DIVMULTBusy, EXE_Hi, EXE_Lo, HiLo_We
  );

endinterface

// File: rtl/div_radix2_core.sv
// Unsigned radix-2 restoring divider: one quotient bit per cycle, done on the 32nd iteration
// with q/r presented combinationally that cycle; flush or rst abandons the division.
module div_radix2_core
  import cpu_defs_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         flush,
  input  logic [W-1:0] dvd_i,
  input  logic [W-1:0] dvs_i,
  output logic [W-1:0] q_o,
  output logic [W-1:0] r_o,
  output logic         done_o
);

  localparam int CW = $clog2(MDU_DIV_ITER);

  logic          run_q, run_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  dvs_q, dvs_d;

  logic [W:0]    shifted;
  logic [W:0]    diff;
  logic          fits;
  logic [W-1:0]  rem_nx;
  logic [W-1:0]  quo_nx;

  // Dividend bits shift out of quo_q into the partial remainder as quotient bits shift in.
  assign shifted = {rem_q, quo_q[W-1]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign fits    = ~diff[W];
  assign rem_nx  = fits ? diff[W-1:0] : shifted[W-1:0];
  assign quo_nx  = {quo_q[W-2:0], fits};

  assign done_o = run_q && (cnt_q == CW'(MDU_DIV_ITER - 1));
  assign q_o    = quo_nx;
  assign r_o    = rem_nx;

  always_comb begin
    run_d = run_q;
    cnt_d = cnt_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    if (flush) begin
      run_d = 1'b0;
    end else if (start) begin
      run_d = 1'b1;
      cnt_d = '0;
      quo_d = dvd_i;
      rem_d = '0;
      dvs_d = dvs_i;
    end else if (run_q) begin
      quo_d = quo_nx;
      rem_d = rem_nx;
      cnt_d = cnt_q + CW'(1);
      if (done_o) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
    end
  end

endmodule

// File: rtl/div_mult_engine.sv
// EXE multiply/divide unit: MULT busy MUL_STAGES cycles, DIV busy 33 cycles, then holds results in DONE.
// Busy asserts combinationally on the start cycle; results are written only when EXE advances (EXE_Wr).
module div_mult_engine
  import cpu_defs_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  div_mult_engine_if.slave   bus
);

  localparam int W   = DATA_W;
  localparam int MCW = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;

  mdu_state_t     state_q, state_d;
  logic [W-1:0]   a_mag_q, a_mag_d;
  logic [W-1:0]   b_mag_q, b_mag_d;
  logic [W-1:0]   a_raw_q, a_raw_d;
  logic           signed_q, signed_d;
  logic           qsign_q, qsign_d;
  logic           rsign_q, rsign_d;
  logic           bzero_q, bzero_d;
  logic [MCW-1:0] mul_cnt_q, mul_cnt_d;
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;

  logic           signed_in, is_mul_in, start;
  logic [W-1:0]   a_mag_in, b_mag_in;
  logic [W-1:0]   mul_a, mul_b;
  logic           mul_neg;
  logic [2*W-1:0] prod_mag, prod;
  logic [W-1:0]   core_q, core_r;
  logic           core_done;
  logic [W-1:0]   div_hi, div_lo;

  assign signed_in = (bus.EXE_MdOp == MDU_MULT) || (bus.EXE_MdOp == MDU_DIV);
  assign is_mul_in = (bus.EXE_MdOp == MDU_MULT) || (bus.EXE_MdOp == MDU_MULTU);
  assign a_mag_in  = (signed_in && bus.EXE_SrcA[W-1]) ? -bus.EXE_SrcA : bus.EXE_SrcA;
  assign b_mag_in  = (signed_in && bus.EXE_SrcB[W-1]) ? -bus.EXE_SrcB : bus.EXE_SrcB;

  // start deliberately ignores EXE_DisWr: Control derives DisWr from our own busy.
  assign start = (state_q == ST_IDLE) && (bus.EXE_MdOp != MDU_NONE)
                 && !bus.Flush_Exception && !rst;

  // Operands come straight from the bus on the start cycle so MUL_STAGES==1 still works.
  assign mul_a    = start ? a_mag_in : a_mag_q;
  assign mul_b    = start ? b_mag_in : b_mag_q;
  assign mul_neg  = start ? (signed_in && (bus.EXE_SrcA[W-1] ^ bus.EXE_SrcB[W-1]))
                          : (signed_q && qsign_q);
  assign prod_mag = {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};
  assign prod     = mul_neg ? -prod_mag : prod_mag;

  div_radix2_core #(.W(W)) u_div (
    .clk    (clk),
    .rst    (rst),
    .start  (start && !is_mul_in),
    .flush  (bus.Flush_Exception),
    .dvd_i  (a_mag_in),
    .dvs_i  (b_mag_in),
    .q_o    (core_q),
    .r_o    (core_r),
    .done_o (core_done)
  );

  // Divide by zero reports the raw dividend, so it bypasses the sign fix-up.
  assign div_lo = bzero_q ? {W{1'b1}} : ((signed_q && qsign_q) ? -core_q : core_q);
  assign div_hi = bzero_q ? a_raw_q   : ((signed_q && rsign_q) ? -core_r : core_r);

  always_comb begin
    state_d   = state_q;
    a_mag_d   = a_mag_q;
    b_mag_d   = b_mag_q;
    a_raw_d   = a_raw_q;
    signed_d  = signed_q;
    qsign_d   = qsign_q;
    rsign_d   = rsign_q;
    bzero_d   = bzero_q;
    mul_cnt_d = mul_cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_mag_d   = a_mag_in;
          b_mag_d   = b_mag_in;
          a_raw_d   = bus.EXE_SrcA;
          signed_d  = signed_in;
          qsign_d   = bus.EXE_SrcA[W-1] ^ bus.EXE_SrcB[W-1];
          rsign_d   = bus.EXE_SrcA[W-1];
          bzero_d   = (bus.EXE_SrcB == '0);
          mul_cnt_d = MCW'(1);
          if (!is_mul_in) begin
            state_d = ST_DIV;
          end else if (MUL_STAGES == 1) begin
            state_d = ST_DONE;
            {hi_d, lo_d} = prod;
          end else begin
            state_d = ST_MUL;
          end
        end
      end
      ST_MUL: begin
        if (mul_cnt_q == MCW'(MUL_STAGES - 1)) begin
          state_d = ST_DONE;
          {hi_d, lo_d} = prod;
        end else begin
          mul_cnt_d = mul_cnt_q + MCW'(1);
        end
      end
      ST_DIV: begin
        if (core_done) begin
          state_d = ST_DONE;
          hi_d    = div_hi;
          lo_d    = div_lo;
        end
      end
      default: begin
        if (bus.EXE_Wr) state_d = ST_IDLE;
      end
    endcase
    if (bus.Flush_Exception) begin
      state_d = ST_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      a_mag_q   <= '0;
      b_mag_q   <= '0;
      a_raw_q   <= '0;
      signed_q  <= 1'b0;
      qsign_q   <= 1'b0;
      rsign_q   <= 1'b0;
      bzero_q   <= 1'b0;
      mul_cnt_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      a_mag_q   <= a_mag_d;
      b_mag_q   <= b_mag_d;
      a_raw_q   <= a_raw_d;
      signed_q  <= signed_d;
      qsign_q   <= qsign_d;
      rsign_q   <= rsign_d;
      bzero_q   <= bzero_d;
      mul_cnt_q <= mul_cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign bus.DIVMULTBusy = start || (state_q == ST_MUL) || (state_q == ST_DIV);
  assign bus.HiLo_We     = (state_q == ST_DONE) && bus.EXE_Wr && !bus.EXE_DisWr
                           && !bus.Flush_Exception;
  assign bus.EXE_Hi      = hi_q;
  assign bus.EXE_Lo      = lo_q;

endmodule

// File: tb/tb_div_mult_engine.sv
// Vector table plus random ops against an arithmetic reference; hand sequences for flush and reset.
module tb_div_mult_engine;
  import cpu_defs_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  div_mult_engine_if #(.DATA_W(32)) bus_if ();

  div_mult_engine #(.DATA_W(32), .MUL_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  typedef struct {
    mdu_op_t     op;
    logic [31:0] a;
    logic [31:0] b;
    int          wd;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int we_pulses = 0;
  logic [31:0] last_hi, last_lo;

  always begin
    @(negedge clk);
    #3;
    if (bus_if.HiLo_We === 1'b1) we_pulses++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic void model(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo);
    longint p;
    int     q, r;
    hi = 0;
    lo = 0;
    case (op)
      MDU_MULTU: begin
        p = longint'({32'b0, a}) * longint'({32'b0, b});
        {hi, lo} = p;
      end
      MDU_MULT: begin
        p = longint'($signed(a)) * longint'($signed(b));
        {hi, lo} = p;
      end
      MDU_DIVU: begin
        if (b == 0) begin hi = a; lo = 32'hFFFF_FFFF; end
        else begin lo = a / b; hi = a % b; end
      end
      MDU_DIV: begin
        if (b == 0) begin hi = a; lo = 32'hFFFF_FFFF; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin hi = 0; lo = 32'h8000_0000; end
        else begin
          q = $signed(a) / $signed(b);
          r = $signed(a) % $signed(b);
          lo = q;
          hi = r;
        end
      end
      default: ;
    endcase
  endfunction

  task automatic do_op(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b, input int wd,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int exp_lat);
    int lat;
    int w0;
    @(negedge clk);
    bus_if.EXE_MdOp = op;
    bus_if.EXE_SrcA = a;
    bus_if.EXE_SrcB = b;
    bus_if.EXE_Wr   = 1'b0;
    w0  = we_pulses;
    lat = 0;
    #1;
    while (bus_if.DIVMULTBusy === 1'b1 && lat < 100) begin
      lat++;
      @(negedge clk);
      #1;
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    for (int i = 0; i < wd; i++) begin
      chk("hold_busy", 64'(bus_if.DIVMULTBusy), 64'(0));
      chk("hold_we", 64'(bus_if.HiLo_We), 64'(0));
      chk("hold_hi", 64'(bus_if.EXE_Hi), 64'(exp_hi));
      chk("hold_lo", 64'(bus_if.EXE_Lo), 64'(exp_lo));
      @(negedge clk);
      #1;
    end
    bus_if.EXE_Wr = 1'b1;
    #1;
    chk("we_pulse", 64'(bus_if.HiLo_We), 64'(1));
    chk("done_busy", 64'(bus_if.DIVMULTBusy), 64'(0));
    chk("hi", 64'(bus_if.EXE_Hi), 64'(exp_hi));
    chk("lo", 64'(bus_if.EXE_Lo), 64'(exp_lo));
    @(negedge clk);
    bus_if.EXE_MdOp = MDU_NONE;
    bus_if.EXE_Wr   = 1'b0;
    #1;
    chk("idle_busy", 64'(bus_if.DIVMULTBusy), 64'(0));
    #3;
    chk("we_count", 64'(we_pulses - w0), 64'(1));
    last_hi = exp_hi;
    last_lo = exp_lo;
  endtask

  vec_t vecs[9];

  initial begin
    int w0;
    logic [31:0] eh, el;
    mdu_op_t rop;
    logic [31:0] ra, rb;

    vecs[0] = '{MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFE, 32'h0000_0001, 2};
    vecs[1] = '{MDU_DIV,   32'hFFFF_FFF9, 32'd2,         0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
    vecs[2] = '{MDU_DIVU,  32'd100,       32'd0,         0, 32'd100,       32'hFFFF_FFFF, 33};
    vecs[3] = '{MDU_DIVU,  32'd10,        32'd3,         5, 32'd1,         32'd3,         33};
    vecs[4] = '{MDU_MULT,  32'hFFFF_FFFD, 32'd5,         1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 2};
    vecs[5] = '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h0,         32'h8000_0000, 33};
    vecs[6] = '{MDU_DIV,   32'hFFFF_FF9C, 32'd0,         0, 32'hFFFF_FF9C, 32'hFFFF_FFFF, 33};
    vecs[7] = '{MDU_MULT,  32'h8000_0000, 32'h8000_0000, 0, 32'h4000_0000, 32'h0,         2};
    vecs[8] = '{MDU_DIV,   32'd7,         32'hFFFF_FFFE, 2, 32'd1,         32'hFFFF_FFFD, 33};

    bus_if.EXE_MdOp        = MDU_DIV;
    bus_if.EXE_SrcA        = 32'd5;
    bus_if.EXE_SrcB        = 32'd1;
    bus_if.EXE_Wr          = 1'b0;
    bus_if.EXE_DisWr       = 1'b0;
    bus_if.Flush_Exception = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("busy_in_rst", 64'(bus_if.DIVMULTBusy), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    bus_if.EXE_MdOp = MDU_NONE;
    #1;
    chk("rst_busy", 64'(bus_if.DIVMULTBusy), 64'(0));
    chk("rst_hi", 64'(bus_if.EXE_Hi), 64'(0));
    chk("rst_lo", 64'(bus_if.EXE_Lo), 64'(0));
    chk("rst_we", 64'(bus_if.HiLo_We), 64'(0));

    for (int i = 0; i < 9; i++)
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].wd, vecs[i].hi, vecs[i].lo, vecs[i].lat);

    // Flush partway through a divide.
    @(negedge clk);
    bus_if.EXE_MdOp = MDU_DIV;
    bus_if.EXE_SrcA = 32'hFFFF_FFCE;
    bus_if.EXE_SrcB = 32'd7;
    w0 = we_pulses;
    repeat (10) @(negedge clk);
    bus_if.Flush_Exception = 1'b1;
    @(negedge clk);
    bus_if.Flush_Exception = 1'b0;
    bus_if.EXE_MdOp = MDU_NONE;
    #1;
    chk("flush_busy", 64'(bus_if.DIVMULTBusy), 64'(0));
    chk("flush_hi", 64'(bus_if.EXE_Hi), 64'(last_hi));
    chk("flush_lo", 64'(bus_if.EXE_Lo), 64'(last_lo));
    #3;
    chk("flush_we", 64'(we_pulses - w0), 64'(0));
    do_op(MDU_MULT, 32'd3, 32'd4, 0, 32'd0, 32'd12, 2);

    // Reset partway through a divide.
    @(negedge clk);
    bus_if.EXE_MdOp = MDU_DIVU;
    bus_if.EXE_SrcA = 32'd1000;
    bus_if.EXE_SrcB = 32'd3;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus_if.EXE_MdOp = MDU_NONE;
    #1;
    chk("mrst_busy", 64'(bus_if.DIVMULTBusy), 64'(0));
    chk("mrst_hi", 64'(bus_if.EXE_Hi), 64'(0));
    chk("mrst_lo", 64'(bus_if.EXE_Lo), 64'(0));
    w0 = we_pulses;
    bus_if.EXE_Wr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("mrst_quiet", 64'(bus_if.DIVMULTBusy), 64'(0));
    end
    bus_if.EXE_Wr = 1'b0;
    #3;
    chk("mrst_we", 64'(we_pulses - w0), 64'(0));

    for (int n = 0; n < 30; n++) begin
      rop = mdu_op_t'(3'($urandom_range(1, 4)));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 9));
        default: rb = $urandom;
      endcase
      model(rop, ra, rb, eh, el);
      do_op(rop, ra, rb, $urandom_range(0, 3), eh, el,
            (rop == MDU_MULT || rop == MDU_MULTU) ? 2 : 33);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
